imu_spi_responder: RTL and testbench

//  SPI mode-3 slave that emulates the MPU-side register interface, driving miso for our SPI master
//  (burst read of ACCEL_XOUT_H..ZOUT_L starting at reg 59). Used as an on-board IMU model for

---
 rtl/imu_spi_responder_if.sv | 11 +
 rtl/imu_spi_responder.sv | 165 ++++++++++++++++
 tb/tb_imu_spi_responder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/imu_spi_responder_if.sv
// rtl/imu_spi_responder_if.sv - SPI pin bundle between the bring-up master and the IMU model.
interface imu_spi_responder_if;
  logic sck;
  logic ncs;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sck, ncs, mosi, input miso, miso_oe);
  modport slave  (input sck, ncs, mosi, output miso, miso_oe);
endinterface

// File: rtl/imu_spi_responder.sv
// rtl/imu_spi_responder.sv - SPI mode-3 IMU register model, oversampled in clk.
// Optional IMU_SPI_WRITE_EN makes regs 0x6B/0x1C writable; otherwise they hold reset values.
module imu_spi_responder #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h71,
  parameter logic [6:0] ACCEL_BASE   = 7'd59,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  imu_spi_responder_if.slave  spi,
  input  logic [15:0]         accel_x,
  input  logic [15:0]         accel_y,
  input  logic [15:0]         accel_z,
  output logic                frame_done,
  output logic [6:0]          last_addr,
  output logic [7:0]          pwr_mgmt_1,
  output logic [7:0]          accel_config
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, ncs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ncs_prev_q;
  logic                   sck_s, ncs_s, mosi_s;
  logic                   sck_rise, sck_fall, ncs_rise, ncs_fall;

  state_t      state_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shift_q;
  logic        rw_q;
  logic [6:0]  ptr_q;
  logic [7:0]  tx_q;
  logic        miso_q;
  logic        frame_done_q;
  logic [6:0]  last_addr_q;
  logic [7:0]  pwr_mgmt_1_q;
  logic [7:0]  accel_config_q;
  logic [47:0] snap_q;
  logic [7:0]  rd_data_d;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // sck edges only count inside a frame; ncs edges are always seen
  assign sck_rise = sck_s & ~sck_prev_q & ~ncs_s;
  assign sck_fall = ~sck_s & sck_prev_q & ~ncs_s;
  assign ncs_fall = ~ncs_s & ncs_prev_q;
  assign ncs_rise = ncs_s & ~ncs_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '1;
      ncs_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b1;
      ncs_prev_q  <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi.sck};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
      sck_prev_q  <= sck_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  always_comb begin
    rd_data_d = 8'h00;
    if      (ptr_q == ACCEL_BASE)         rd_data_d = snap_q[47:40];
    else if (ptr_q == ACCEL_BASE + 7'd1)  rd_data_d = snap_q[39:32];
    else if (ptr_q == ACCEL_BASE + 7'd2)  rd_data_d = snap_q[31:24];
    else if (ptr_q == ACCEL_BASE + 7'd3)  rd_data_d = snap_q[23:16];
    else if (ptr_q == ACCEL_BASE + 7'd4)  rd_data_d = snap_q[15:8];
    else if (ptr_q == ACCEL_BASE + 7'd5)  rd_data_d = snap_q[7:0];
    else if (ptr_q == 7'd117)             rd_data_d = WHO_AM_I_VAL;
    else if (ptr_q == 7'h6B)              rd_data_d = pwr_mgmt_1_q;
    else if (ptr_q == 7'h1C)              rd_data_d = accel_config_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= 3'd7;
      shift_q        <= '0;
      rw_q           <= 1'b0;
      ptr_q          <= '0;
      tx_q           <= '0;
      miso_q         <= 1'b1;
      frame_done_q   <= 1'b0;
      last_addr_q    <= '0;
      pwr_mgmt_1_q   <= 8'h01;
      accel_config_q <= 8'h00;
      snap_q         <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (ncs_rise) begin
        // end of frame: any partial byte is simply dropped
        state_q      <= IDLE;
        miso_q       <= 1'b1;
        frame_done_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (ncs_fall) begin
              state_q   <= ADDR;
              snap_q    <= {accel_x, accel_y, accel_z};
              bit_cnt_q <= 3'd7;
              miso_q    <= 1'b1;
            end
          end
          ADDR: begin
            if (sck_rise) begin
              shift_q <= {shift_q[5:0], mosi_s};
              if (bit_cnt_q == 3'd0) begin
                rw_q        <= shift_q[6];
                ptr_q       <= {shift_q[5:0], mosi_s};
                last_addr_q <= {shift_q[5:0], mosi_s};
                bit_cnt_q   <= 3'd7;
                state_q     <= DATA;
              end else begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
              end
            end
          end
          DATA: begin
            // bit_cnt 7 on a falling edge means a fresh byte starts here
            if (sck_fall && rw_q) begin
              if (bit_cnt_q == 3'd7) begin
                miso_q <= rd_data_d[7];
                tx_q   <= {rd_data_d[6:0], 1'b0};
              end else begin
                miso_q <= tx_q[7];
                tx_q   <= {tx_q[6:0], 1'b0};
              end
            end
            if (sck_rise) begin
              shift_q <= {shift_q[5:0], mosi_s};
              if (bit_cnt_q == 3'd0) begin
`ifdef IMU_SPI_WRITE_EN
                if (!rw_q) begin
                  if (ptr_q == 7'h6B)      pwr_mgmt_1_q   <= {shift_q, mosi_s};
                  else if (ptr_q == 7'h1C) accel_config_q <= {shift_q, mosi_s};
                end
`endif
                ptr_q     <= ptr_q + 7'd1;
                bit_cnt_q <= 3'd7;
              end else begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spi.miso     = miso_q;
  assign spi.miso_oe  = ~ncs_s;
  assign frame_done   = frame_done_q;
  assign last_addr    = last_addr_q;
  assign pwr_mgmt_1   = pwr_mgmt_1_q;
  assign accel_config = accel_config_q;

endmodule

// File: tb/tb_imu_spi_responder.sv
// tb/tb_imu_spi_responder.sv - directed bench for the IMU SPI responder.
module tb_imu_spi_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        frame_done;
  logic [6:0]  last_addr;
  logic [7:0]  pwr_mgmt_1, accel_config;
  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;

  imu_spi_responder_if spi();

  imu_spi_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi          (spi),
    .accel_x      (accel_x),
    .accel_y      (accel_y),
    .accel_z      (accel_z),
    .frame_done   (frame_done),
    .last_addr    (last_addr),
    .pwr_mgmt_1   (pwr_mgmt_1),
    .accel_config (accel_config)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  // mode 3: drive mosi on the falling sck, sample miso on the rising sck
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi.sck  = 1'b0;
      spi.mosi = tx[i];
      #50;
      spi.sck  = 1'b1;
      rx[i]    = spi.miso;
      #50;
    end
  endtask

  task automatic frame_begin();
    spi.ncs = 1'b0;
    #100;
  endtask

  task automatic frame_end();
    #100;
    spi.ncs = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spi.ncs = 1'b1; spi.sck = 1'b1; spi.mosi = 1'b0;
    accel_x = 16'h1234; accel_y = 16'h5678; accel_z = 16'h9ABC;
    #30;
    checks++; if (spi.miso !== 1'b1) begin errors++; $display("FAIL reset_miso: got %b expected 1", spi.miso); end
    checks++; if (spi.miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe: got %b expected 0", spi.miso_oe); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (last_addr !== 7'd0) begin errors++; $display("FAIL reset_last_addr: got %h expected 00", last_addr); end
    checks++; if (pwr_mgmt_1 !== 8'h01) begin errors++; $display("FAIL reset_pwr_mgmt_1: got %h expected 01", pwr_mgmt_1); end
    checks++; if (accel_config !== 8'h00) begin errors++; $display("FAIL reset_accel_config: got %h expected 00", accel_config); end
    rst_n = 1'b1;
    #50;
  endtask

  task automatic burst59(input string tag);
    logic [7:0] rx;
    logic [7:0] exp [6];
    int fd0;
    exp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    fd0 = fd_cnt;
    frame_begin();
    checks++; if (spi.miso_oe !== 1'b1) begin errors++; $display("FAIL %s_miso_oe: got %b expected 1", tag, spi.miso_oe); end
    xfer(8'hBB, 8, rx);
    checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL %s_addr_miso: got %h expected ff", tag, rx); end
    for (int k = 0; k < 6; k++) begin
      xfer(8'h00, 8, rx);
      checks++; if (rx !== exp[k]) begin errors++; $display("FAIL %s_byte%0d: got %h expected %h", tag, k, rx, exp[k]); end
    end
    frame_end();
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL %s_frame_done: got %0d pulses expected 1", tag, fd_cnt - fd0); end
    checks++; if (last_addr !== 7'd59) begin errors++; $display("FAIL %s_last_addr: got %0d expected 59", tag, last_addr); end
    checks++; if (spi.miso !== 1'b1 || spi.miso_oe !== 1'b0) begin errors++; $display("FAIL %s_idle_pins: got miso=%b oe=%b expected 1/0", tag, spi.miso, spi.miso_oe); end
  endtask

  task automatic test_burst();
    burst59("burst");
  endtask

  task automatic test_snapshot();
    logic [7:0] rx;
    frame_begin();
    accel_x = 16'hFFFF;
    xfer(8'hBB, 8, rx);
    xfer(8'h00, 8, rx);
    checks++; if (rx !== 8'h12) begin errors++; $display("FAIL snap_xh: got %h expected 12", rx); end
    xfer(8'h00, 8, rx);
    checks++; if (rx !== 8'h34) begin errors++; $display("FAIL snap_xl: got %h expected 34", rx); end
    frame_end();
    accel_x = 16'h1234;
  endtask

  task automatic test_regmap();
    logic [7:0] rx;
    frame_begin(); xfer(8'hF5, 8, rx); xfer(8'h00, 8, rx); frame_end();
    checks++; if (rx !== 8'h71) begin errors++; $display("FAIL who_am_i: got %h expected 71", rx); end
    frame_begin(); xfer(8'hFF, 8, rx);
    xfer(8'h00, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL reg127: got %h expected 00", rx); end
    xfer(8'h00, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL reg0_wrap: got %h expected 00", rx); end
    frame_end();
    checks++; if (last_addr !== 7'h7F) begin errors++; $display("FAIL wrap_last_addr: got %h expected 7f", last_addr); end
    frame_begin(); xfer(8'hC0, 8, rx);
    xfer(8'h00, 8, rx);
    checks++; if (rx !== 8'hBC) begin errors++; $display("FAIL reg64: got %h expected bc", rx); end
    xfer(8'h00, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL reg65: got %h expected 00", rx); end
    frame_end();
    frame_begin(); xfer(8'hEB, 8, rx); xfer(8'h00, 8, rx); frame_end();
    checks++; if (rx !== 8'h01) begin errors++; $display("FAIL read_pwr_mgmt_1: got %h expected 01", rx); end
  endtask

  task automatic test_write();
    logic [7:0] rx;
    logic [7:0] exp;
`ifdef IMU_SPI_WRITE_EN
    exp = 8'h18;
`else
    exp = 8'h00;
`endif
    frame_begin(); xfer(8'h1C, 8, rx); xfer(8'h18, 8, rx); frame_end();
    checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL write_miso_idle: got %h expected ff", rx); end
    checks++; if (accel_config !== exp) begin errors++; $display("FAIL write_accel_config: got %h expected %h", accel_config, exp); end
    frame_begin(); xfer(8'h9C, 8, rx); xfer(8'h00, 8, rx); frame_end();
    checks++; if (rx !== exp) begin errors++; $display("FAIL readback_accel_config: got %h expected %h", rx, exp); end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int fd0;
    fd0 = fd_cnt;
    frame_begin(); xfer(8'h6B, 8, rx); xfer(8'h00, 4, rx); frame_end();
    checks++; if (pwr_mgmt_1 !== 8'h01) begin errors++; $display("FAIL abort_pwr_mgmt_1: got %h expected 01", pwr_mgmt_1); end
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL abort_frame_done: got %0d pulses expected 1", fd_cnt - fd0); end
    checks++; if (last_addr !== 7'h6B) begin errors++; $display("FAIL abort_last_addr: got %h expected 6b", last_addr); end
    burst59("after_abort");
  endtask

  task automatic test_reset_midread();
    logic [7:0] rx;
    frame_begin(); xfer(8'hBB, 8, rx); xfer(8'h00, 4, rx);
    #20;
    rst_n = 1'b0;
    #1;
    checks++; if (spi.miso !== 1'b1) begin errors++; $display("FAIL midreset_miso: got %b expected 1", spi.miso); end
    checks++; if (spi.miso_oe !== 1'b0) begin errors++; $display("FAIL midreset_miso_oe: got %b expected 0", spi.miso_oe); end
    spi.ncs = 1'b1; spi.sck = 1'b1;
    #49;
    rst_n = 1'b1;
    #100;
    checks++; if (last_addr !== 7'd0) begin errors++; $display("FAIL midreset_last_addr: got %h expected 00", last_addr); end
    burst59("after_reset");
  endtask

  initial begin
    test_reset();
    test_burst();
    test_snapshot();
    test_regmap();
    test_write();
    test_abort();
    test_reset_midread();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
